// File: rtl/dvfs_sequencer.sv
// DVFS sequencer: arbitrates level requests and orders voltage/frequency changes
// so voltage never drops below what the running frequency needs.
module dvfs_sequencer #(
    parameter int NUM_REQ            = 4,
    parameter int VOLT_SETTLE_CYCLES = 64,
    parameter int TIMEOUT_CYCLES     = 4096
) (
    input  logic                   ref_clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [3*NUM_REQ-1:0]   req_level,
    input  logic [2:0]             thermal_cap,
    output logic [NUM_REQ-1:0]     grant,
    output logic [2:0]             volt_level_req,
    output logic                   volt_req,
    input  logic                   volt_ack,
    output logic [2:0]             freq_level_req,
    output logic                   freq_enable,
    input  logic                   freq_ready,
    input  logic [2:0]             freq_current_level,
    output logic [2:0]             active_level,
    output logic                   busy,
    output logic                   error,
    input  logic                   error_clr
);
    localparam int PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CMAX = (TIMEOUT_CYCLES > VOLT_SETTLE_CYCLES) ? TIMEOUT_CYCLES : VOLT_SETTLE_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] TMO_LAST    = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(VOLT_SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, VUP, VUP_WAIT, SETTLE, FSET, FSET_WAIT, VDN, VDN_WAIT
    } state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [2:0]      tgt;
    logic [CW-1:0]   cnt;

    logic [2:0]      lvl [NUM_REQ];
    logic            win_found;
    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   scan_idx;
    logic [2:0]      win_target;
    logic [NUM_REQ-1:0] win_onehot;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lvl
        assign lvl[i] = req_level[3*i +: 3];
    end

    // Round-robin scan starting at the pointer; first valid requester wins.
    always_comb begin
        win_found  = 1'b0;
        win_idx    = '0;
        scan_idx   = '0;
        win_onehot = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = PW'((int'(ptr) + k) % NUM_REQ);
            if (!win_found && req_valid[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
        win_onehot[win_idx] = win_found;
        win_target = (lvl[win_idx] < thermal_cap) ? lvl[win_idx] : thermal_cap;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            ptr            <= '0;
            tgt            <= 3'd4;
            cnt            <= '0;
            grant          <= '0;
            volt_req       <= 1'b0;
            volt_level_req <= 3'd4;
            freq_enable    <= 1'b0;
            freq_level_req <= 3'd4;
            active_level   <= 3'd4;
            error          <= 1'b0;
        end else begin
            grant    <= '0;
            volt_req <= 1'b0;
            // A timeout below overrides this clear in the same cycle.
            if (error_clr) error <= 1'b0;
            case (state)
                IDLE: begin
                    if (!error) begin
                        if (thermal_cap < active_level) begin
                            tgt   <= thermal_cap;
                            state <= FSET;
                        end else if (win_found) begin
                            grant <= win_onehot;
                            ptr   <= PW'((int'(win_idx) + 1) % NUM_REQ);
                            tgt   <= win_target;
                            if (win_target > active_level)      state <= VUP;
                            else if (win_target < active_level) state <= FSET;
                        end
                    end
                end
                VUP: begin
                    volt_level_req <= tgt;
                    volt_req       <= 1'b1;
                    cnt            <= '0;
                    state          <= VUP_WAIT;
                end
                VUP_WAIT: begin
                    if (volt_ack) begin
                        cnt   <= '0;
                        state <= SETTLE;
                    end else if (cnt == TMO_LAST) begin
                        error <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt == SETTLE_LAST) state <= FSET;
                    else                    cnt   <= cnt + 1'b1;
                end
                FSET: begin
                    freq_level_req <= tgt;
                    freq_enable    <= 1'b1;
                    cnt            <= '0;
                    state          <= FSET_WAIT;
                end
                FSET_WAIT: begin
                    if (freq_ready && freq_current_level == tgt) begin
                        freq_enable  <= 1'b0;
                        active_level <= tgt;
                        state        <= (tgt < active_level) ? VDN : IDLE;
                    end else if (cnt == TMO_LAST) begin
                        error       <= 1'b1;
                        freq_enable <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                VDN: begin
                    volt_level_req <= tgt;
                    volt_req       <= 1'b1;
                    cnt            <= '0;
                    state          <= VDN_WAIT;
                end
                VDN_WAIT: begin
                    if (volt_ack) begin
                        state <= IDLE;
                    end else if (cnt == TMO_LAST) begin
                        error <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
